// File: rtl/cpu_defs.sv
// Shared CPU definitions: interrupt controller sizing, vector layout and FSM encoding.
package cpu_defs;

    localparam int          INT_NUM_SRC    = 3;
    localparam int          INT_ID_W       = 2;
    localparam logic [31:0] INT_VEC_BASE   = 32'h0000_0400;
    localparam logic [31:0] INT_VEC_STRIDE = 32'h0000_0040;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } int_state_e;

    // Handler address for a given source id
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [31:0] id);
        return base + id * stride;
    endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Single-source 2-flop synchroniser with rising-edge detection on the synchronised level.
module irq_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic irq_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Synchronise the raw level and keep one delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= irq_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/int_ctrl.sv
// Priority-nested interrupt controller: latches synchronised request edges, requests the
// highest eligible source above the current service level and keeps an EPC stack for nesting.
import cpu_defs::*;

module int_ctrl #(
    parameter int          NUM_SRC    = INT_NUM_SRC,
    parameter int          ID_W       = INT_ID_W,
    parameter logic [31:0] VEC_BASE   = INT_VEC_BASE,
    parameter logic [31:0] VEC_STRIDE = INT_VEC_STRIDE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               int_en,
    input  logic [NUM_SRC-1:0] int_mask,
    input  logic               int_ack,
    input  logic [31:0]        epc_in,
    input  logic               eret,
    output logic               int_req,
    output logic [ID_W-1:0]    int_id,
    output logic [31:0]        int_vector,
    output logic [31:0]        epc_out,
    output logic [NUM_SRC-1:0] in_service,
    output logic [NUM_SRC-1:0] pending,
    output logic [31:0]        int_count
);

    localparam int DEPTH_W = $clog2(NUM_SRC + 1);

    int_state_e         state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [31:0]        vec_q, vec_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] isvc_q, isvc_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [31:0]        stack_q [NUM_SRC];

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] elig_vec;
    logic [NUM_SRC-1:0] isvc_top;
    logic [NUM_SRC-1:0] acc_clr;
    logic               elig_vld;
    logic               isvc_vld;
    logic [ID_W-1:0]    elig_idx;
    logic [ID_W-1:0]    isvc_idx;
    logic               elig_wins;
    logic               eret_ok;
    logic               accept;
    logic               withdraw;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
        irq_edge_sync u_sync (
            .clk    (clk),
            .rst    (rst),
            .irq_i  (irq_in[g]),
            .rise_o (rise[g])
        );
    end

    // Priority encoders: highest eligible pending source and current service level
    always_comb begin
        elig_vec = pend_q & int_mask;
        elig_vld = 1'b0;
        elig_idx = '0;
        isvc_vld = 1'b0;
        isvc_idx = '0;
        isvc_top = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (elig_vec[i]) begin
                elig_vld = 1'b1;
                elig_idx = ID_W'(i);
            end
            if (isvc_q[i]) begin
                isvc_vld = 1'b1;
                isvc_idx = ID_W'(i);
                isvc_top = NUM_SRC'(1) << i;
            end
        end
    end

    // A source may only request when it outranks every handler already running.
    // eret takes precedence over a simultaneous ack, so the ack is simply not accepted.
    assign elig_wins = int_en && elig_vld && (!isvc_vld || (elig_idx > isvc_idx));
    assign eret_ok   = eret && (depth_q != '0);
    assign accept    = (state_q == REQ) && int_ack && !eret;
    assign withdraw  = (state_q == REQ) && (!int_en || !int_mask[id_q]);
    assign acc_clr   = accept ? (NUM_SRC'(1) << id_q) : '0;

    // Request FSM: latch the winner in IDLE, hold it frozen in REQ until accept or withdraw
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (elig_wins) begin
                    state_d = REQ;
                    id_d    = elig_idx;
                    vec_d   = vec_addr(VEC_BASE, VEC_STRIDE, 32'(elig_idx));
                end
            end
            REQ: begin
                if (accept) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + 32'd1;
                end else if (withdraw) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending latch and nesting bookkeeping; an accept-clear beats a same-cycle edge
    always_comb begin
        pend_d  = (pend_q | rise) & ~acc_clr;
        isvc_d  = isvc_q;
        depth_d = depth_q;
        if (eret_ok) begin
            isvc_d  = isvc_q & ~isvc_top;
            depth_d = depth_q - DEPTH_W'(1);
        end else if (accept) begin
            isvc_d  = isvc_q | acc_clr;
            depth_d = depth_q + DEPTH_W'(1);
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= '0;
            isvc_q  <= '0;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            isvc_q  <= isvc_d;
            depth_q <= depth_d;
        end
    end

    // Return-PC storage; entries above depth are never observed, so no reset is needed
    always_ff @(posedge clk) begin
        if (accept) begin
            stack_q[depth_q] <= epc_in;
        end
    end

    assign int_req    = (state_q == REQ);
    assign int_id     = id_q;
    assign int_vector = vec_q;
    assign epc_out    = (depth_q == '0) ? 32'h0 : stack_q[depth_q - DEPTH_W'(1)];
    assign in_service = isvc_q;
    assign pending    = pend_q;
    assign int_count  = cnt_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios then random traffic against a queue-based model.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  irq_in;
    logic        int_en;
    logic [2:0]  int_mask;
    logic        int_ack;
    logic [31:0] epc_in;
    logic        eret;
    logic        int_req;
    logic [1:0]  int_id;
    logic [31:0] int_vector;
    logic [31:0] epc_out;
    logic [2:0]  in_service;
    logic [2:0]  pending;
    logic [31:0] int_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    int_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .int_en     (int_en),
        .int_mask   (int_mask),
        .int_ack    (int_ack),
        .epc_in     (epc_in),
        .eret       (eret),
        .int_req    (int_req),
        .int_id     (int_id),
        .int_vector (int_vector),
        .epc_out    (epc_out),
        .in_service (in_service),
        .pending    (pending),
        .int_count  (int_count)
    );

    // Reference model state
    logic [2:0]  m_pend;
    logic [2:0]  m_isvc;
    logic        m_req;
    logic [1:0]  m_id;
    logic [31:0] m_vec;
    logic [31:0] m_cnt;
    logic [31:0] m_stack[$];
    logic [2:0]  m_hist[$];   // irq_in seen at past clock edges, newest first

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int top_bit(input logic [2:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 3; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        m_pend = '0;
        m_isvc = '0;
        m_req  = 1'b0;
        m_id   = '0;
        m_vec  = '0;
        m_cnt  = '0;
        m_stack.delete();
        m_hist.delete();
        for (int i = 0; i < 3; i++) m_hist.push_back(3'b000);
    endtask

    task automatic model_step();
        logic [2:0] rise;
        logic [2:0] clr;
        logic [2:0] elig;
        int         cur;
        int         top;
        if (rst) begin
            model_reset();
        end else begin
            // level must have been seen high two edges ago after being low three edges ago
            rise = m_hist[1] & ~m_hist[2];
            cur  = top_bit(m_isvc);
            elig = m_pend & int_mask;
            top  = top_bit(elig);
            clr  = '0;
            if (m_req) begin
                if (int_ack && !eret) begin
                    m_stack.push_back(epc_in);
                    m_isvc[m_id] = 1'b1;
                    clr[m_id]    = 1'b1;
                    m_cnt        = m_cnt + 32'd1;
                    m_req        = 1'b0;
                end else if (!int_en || !int_mask[m_id]) begin
                    m_req = 1'b0;
                end
            end else if (int_en && top >= 0 && top > cur) begin
                m_req = 1'b1;
                m_id  = 2'(top);
                m_vec = 32'h400 + 32'(top) * 32'h40;
            end
            if (eret && m_stack.size() > 0) begin
                void'(m_stack.pop_back());
                m_isvc[cur] = 1'b0;
            end
            m_pend = (m_pend | rise) & ~clr;
            m_hist.push_front(irq_in);
            void'(m_hist.pop_back());
        end
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, ".req"},  {31'b0, int_req}, {31'b0, m_req});
        check_val({tag, ".id"},   32'(int_id),      32'(m_id));
        check_val({tag, ".vec"},  int_vector,       m_vec);
        check_val({tag, ".epc"},  epc_out,          (m_stack.size() > 0) ? m_stack[$] : 32'h0);
        check_val({tag, ".isvc"}, 32'(in_service),  32'(m_isvc));
        check_val({tag, ".pend"}, 32'(pending),     32'(m_pend));
        check_val({tag, ".cnt"},  int_count,        m_cnt);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic pulse_irq(input int src, input int cycles);
        irq_in = 3'(1 << src);
        tick("irq");
        irq_in = 3'b000;
        repeat (cycles - 1) tick("irq");
    endtask

    task automatic do_ack(input logic [31:0] pc);
        int_ack = 1'b1;
        epc_in  = pc;
        tick("ack");
        int_ack = 1'b0;
    endtask

    task automatic do_eret();
        eret = 1'b1;
        tick("eret");
        eret = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        irq_in   = '0;
        int_en   = 1'b1;
        int_mask = 3'b111;
        int_ack  = 1'b0;
        eret     = 1'b0;
        epc_in   = '0;
        model_reset();
        #1;
        compare_all("rst0");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single request and accept
        pulse_irq(0, 4);
        check_val("p2_req", {31'b0, int_req}, 32'd1);
        check_val("p2_id",  32'(int_id),      32'd0);
        check_val("p2_vec", int_vector,       32'h400);
        do_ack(32'h100);
        check_val("p2_isvc", 32'(in_service), 32'b001);
        check_val("p2_epc",  epc_out,         32'h100);
        check_val("p2_cnt",  int_count,       32'd1);

        // Asynchronous reset while requesting with a non-empty stack
        pulse_irq(1, 4);
        check_val("p1_pend", 32'(pending),     32'b010);
        check_val("p1_req",  {31'b0, int_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_val("p1_rst_req",  {31'b0, int_req}, 32'd0);
        check_val("p1_rst_pend", 32'(pending),     32'd0);
        check_val("p1_rst_isvc", 32'(in_service),  32'd0);
        check_val("p1_rst_epc",  epc_out,          32'd0);
        check_val("p1_rst_cnt",  int_count,        32'd0);
        check_val("p1_rst_vec",  int_vector,       32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick("p1_rel");
        check_val("p1_rel_req", {31'b0, int_req}, 32'd0);

        // Nesting: source 2 preempts source 0
        pulse_irq(0, 4);
        do_ack(32'h100);
        pulse_irq(2, 4);
        check_val("p3_id",  32'(int_id), 32'd2);
        check_val("p3_vec", int_vector,  32'h480);
        do_ack(32'h404);
        check_val("p3_isvc", 32'(in_service), 32'b101);
        check_val("p3_epc",  epc_out,         32'h404);
        do_eret();
        check_val("p3_isvc1", 32'(in_service), 32'b001);
        check_val("p3_epc1",  epc_out,         32'h100);
        do_eret();
        check_val("p3_isvc0", 32'(in_service), 32'b000);
        check_val("p3_epc0",  epc_out,         32'h0);

        // Lower priority waits for the running handler to return
        pulse_irq(2, 4);
        do_ack(32'h500);
        pulse_irq(1, 5);
        check_val("p4_pend", 32'(pending),     32'b010);
        check_val("p4_req",  {31'b0, int_req}, 32'd0);
        do_eret();
        check_val("p4_req_e", {31'b0, int_req}, 32'd0);
        tick("p4");
        check_val("p4_req1", {31'b0, int_req}, 32'd1);
        check_val("p4_id1",  32'(int_id),      32'd1);

        // Withdraw on int_en drop, then re-issue
        int_en = 1'b0;
        tick("p5");
        int_en = 1'b1;
        check_val("p5_wd_req",  {31'b0, int_req}, 32'd0);
        check_val("p5_wd_pend", 32'(pending),     32'b010);
        tick("p5");
        check_val("p5_re_req", {31'b0, int_req}, 32'd1);
        do_ack(32'h200);

        // Collisions: eret with ack, eret on empty stack
        pulse_irq(2, 4);
        check_val("p6_req", {31'b0, int_req}, 32'd1);
        int_ack = 1'b1;
        eret    = 1'b1;
        tick("p6");
        int_ack = 1'b0;
        eret    = 1'b0;
        check_val("p6_isvc", 32'(in_service), 32'b000);
        check_val("p6_req1", {31'b0, int_req}, 32'd1);
        do_ack(32'h600);
        check_val("p6_isvc2", 32'(in_service), 32'b100);
        do_eret();
        do_eret();
        check_val("p6_empty_isvc", 32'(in_service), 32'd0);
        check_val("p6_empty_epc",  epc_out,         32'd0);
        check_val("p6_cnt",        int_count,       32'd5);

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) irq_in = 3'($urandom);
            int_en   = ($urandom_range(0, 9) != 0);
            int_mask = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            int_ack  = ($urandom_range(0, 2) == 0);
            eret     = ($urandom_range(0, 9) == 0);
            epc_in   = $urandom;
            tick("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
